mult_accumulator: RTL
=====================

# mult_accumulator

Downstream consumer of the `WIDTH`-bit multiplier's products. It accepts one unsigned product per valid/ready handshake and sums `NUM_TERMS` consecutive products into an accumulator. It then presents the sum, with an overflow flag, on an output handshake. Together with the multiplier it forms a dot-product / MAC path. It runs on the same single clock as the multiplier and its interface.

## Interface
- `WIDTH`, default 5: operand width of the upstream multiplier; products are `2*WIDTH` bits.
- `NUM_TERMS`, default 4: number of products summed per result; must be at least 2.
- `ACC_W`, default 12: accumulator and sum width; must be at least `2*WIDTH`.
- `clk`, input, 1: clock, rising-edge active.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `clr`, input, 1: synchronous clear; discards any partial sum.
- `in_valid`, input, 1: `in_product` is valid.
- `in_ready`, output, 1: block can accept a product.
- `in_product`, input, `2*WIDTH`: unsigned product from the multiplier.
- `out_valid`, output, 1: `out_sum` and `out_ovf` are valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_sum`, output, `ACC_W`: accumulated sum, modulo `2^ACC_W`.
- `out_ovf`, output, 1: at least one addition in this result carried out of `ACC_W` bits.
- `term_cnt`, output, `$clog2(NUM_TERMS)+1`: products accepted into the current sum.

## Operation
- The FSM has two states: ACCUM and HOLD.
- **ACCUM**
  - `in_ready` = 1 and `out_valid` = 0.
  - On an input handshake (`in_valid` && `in_ready`): `acc <= acc + in_product`, zero-extended to `ACC_W`.
  - A carry out of bit `ACC_W-1` sets the sticky `ovf`.
  - `term_cnt` increments on each handshake.
  - On the handshake where `term_cnt == NUM_TERMS-1`: the final sum loads `out_sum`, `ovf` loads `out_ovf`, and the FSM moves to HOLD.
- **HOLD**
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_sum`, `out_ovf` and `term_cnt` (= `NUM_TERMS`) stay stable until the output handshake.
  - On `out_valid` && `out_ready`: `acc`, `ovf` and `term_cnt` go to 0, and the FSM moves to ACCUM.
- **`clr`**
  - Highest priority after reset, effective in both states.
  - Next cycle: ACCUM with `acc`, `ovf`, `term_cnt` and `out_valid` all 0.
  - Any input or output handshake in the same cycle as `clr` is ignored, so the product is lost and the result is dropped.
- Arithmetic is unsigned throughout, with wrap-around modulo `2^ACC_W`; there is no saturation.
- A product of 0 still counts as a term.
- `in_valid` while `in_ready` = 0 has no effect. The upstream must hold its data.

## Timing
- **Reset** (`rst_n` low, asynchronous, any state): ACCUM, `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_ovf` = 0, `term_cnt` = 0. This takes effect immediately, without waiting for a clock edge. Release is synchronous to `clk`.
- **Throughput:** one product per cycle in ACCUM.
- **Latency:** `out_valid` rises the cycle after the `NUM_TERMS`-th input handshake.
- **Minimum HOLD duration:** 1 cycle, when `out_ready` is already high.
  - The earliest next input is the cycle after the output handshake.
  - Best-case period is `NUM_TERMS+1` cycles per result.
- **No same-cycle bypass:** `in_ready` stays 0 during the cycle in which the output handshake occurs.
- **Output stability:** while `out_valid` = 1 && `out_ready` = 0, all outputs are held.
- **Reset mid-operation:** a partial sum or pending result is lost, and no `out_valid` pulse is produced.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-accumulation (2 terms in) → outputs go to reset values without a clock edge. After release, 4 products of 1 → `out_sum` = 4.
- **Full-scale sum** (`WIDTH` = 5, `ACC_W` = 12): 4 back-to-back products of 961 (31×31) → `out_sum` = 3844, `out_ovf` = 0, `out_valid` 1 cycle after the 4th handshake.
- **Overflow** (`ACC_W` = 11): same stimulus as the full-scale test → `out_sum` = 1796, `out_ovf` = 1. The next result (four products of 1) → 4, `out_ovf` = 0.
- **Backpressure:** products 10, 20, 30, 40 with `in_valid` gaps; hold `out_ready` low for 5 cycles → `out_sum` = 100, stable. `in_ready` = 0 throughout; a product of 7 offered in HOLD is not counted in the next sum.
- **Clear:** accept 5 and 6, then pulse `clr` together with `in_valid` (product 9), then send products 1, 2, 3, 4 → `out_sum` = 10.
- **Handshake protocol:** random `in_valid`/`out_ready` over 200 results, checked against a reference-model sum → every sum matches, with no lost or duplicated products.

Source files
------------

// File: rtl/mult_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : mult_accumulator
// Description : Sums NUM_TERMS unsigned products into one result with a
//               sticky carry-out flag, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_accumulator #(
    parameter int WIDTH     = 5,
    parameter int NUM_TERMS = 4,
    parameter int ACC_W     = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2*WIDTH-1:0]            in_product,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_sum,
    output logic                          out_ovf,
    output logic [$clog2(NUM_TERMS):0]    term_cnt
);

    localparam int c_prod_w = 2 * WIDTH;
    localparam int c_cnt_w  = $clog2(NUM_TERMS) + 1;

    localparam logic [0:0] c_st_accum = 1'b0;
    localparam logic [0:0] c_st_hold  = 1'b1;

    localparam logic [c_cnt_w-1:0] c_last_term = c_cnt_w'(NUM_TERMS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    logic [0:0]         r_state;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [c_cnt_w-1:0] r_term_cnt;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_ovf;

    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W:0]     w_sum;
    logic               w_ovf_next;
    logic               w_in_hs;
    logic               w_out_hs;
    logic               w_last;

    // Zero-extension needs no padding when the accumulator is exactly product-wide.
    generate
        if (ACC_W > c_prod_w) begin : g_ext_pad
            assign w_prod_ext = {{(ACC_W - c_prod_w){1'b0}}, in_product};
        end else begin : g_ext_none
            assign w_prod_ext = in_product;
        end
    endgenerate

    assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};
    assign w_ovf_next = r_ovf | w_sum[ACC_W];

    assign in_ready  = (r_state == c_st_accum);
    assign out_valid = (r_state == c_st_hold);
    assign w_in_hs   = in_valid & in_ready;
    assign w_out_hs  = out_valid & out_ready;
    assign w_last    = (r_term_cnt == c_last_term);

    assign out_sum  = r_out_sum;
    assign out_ovf  = r_out_ovf;
    assign term_cnt = r_term_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_accum;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_term_cnt <= '0;
            r_out_sum  <= '0;
            r_out_ovf  <= 1'b0;
        end else if (clr) begin
            // Handshakes coinciding with clr are deliberately discarded.
            r_state    <= c_st_accum;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_term_cnt <= '0;
        end else begin
            case (r_state)
                c_st_accum: begin
                    if (w_in_hs) begin
                        r_acc      <= w_sum[ACC_W-1:0];
                        r_ovf      <= w_ovf_next;
                        r_term_cnt <= r_term_cnt + c_cnt_one;
                        if (w_last) begin
                            r_out_sum <= w_sum[ACC_W-1:0];
                            r_out_ovf <= w_ovf_next;
                            r_state   <= c_st_hold;
                        end
                    end
                end
                c_st_hold: begin
                    if (w_out_hs) begin
                        r_acc      <= '0;
                        r_ovf      <= 1'b0;
                        r_term_cnt <= '0;
                        r_state    <= c_st_accum;
                    end
                end
                default: begin
                    r_state <= c_st_accum;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
